nand_flash_target: RTL and testbench
====================================

Name: nand_flash_target

Overview:
- Synthesizable, clocked emulator of the small-page NAND flash device at the far end of the NAND interface that the flash controller drives (IO[7:0], CLE, ALE, REN, WEN, R/B).
- Decodes command, address and data cycles into a 512-byte page register.
- Moves pages to and from an external byte-wide backing memory of 2^PAGE_BITS pages x 512 bytes.
- Emulates busy time on R/B; used on FPGA/in-system builds in place of the behavioural flash models.

Parameters:
PAGE_BITS, 9, page address width (512 pages)
TR_CYCLES, 50, extra busy cycles after a page load completes
TPROG_CYCLES, 200, extra busy cycles after a page write-back completes
TRST_CYCLES, 8, busy cycles after reset command FFh

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
f_io_in  in  8  IO bus value from the controller
f_io_out  out  8  IO bus value driven by the target
f_io_oe  out  1  target drives IO when 1
f_cle  in  1  command latch enable
f_ale  in  1  address latch enable
f_ren  in  1  read enable, active low
f_wen  in  1  write enable, active low
f_rb  out  1  ready(1)/busy(0)
mem_addr  out  PAGE_BITS+9  backing memory byte address {page, column}
mem_re  out  1  backing memory read strobe
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_re
mem_we  out  1  backing memory write strobe
mem_wdata  out  8  write data

Behaviour:
- Reset (rst_n=0, async): state IDLE; f_rb=1, f_io_oe=0, f_io_out=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0; column, page and address counter cleared. Page register contents are not reset.
- Input sampling: f_cle, f_ale, f_wen, f_ren and f_io_in each pass through a 2-flop synchronizer. f_io_in is delayed identically so it stays aligned with f_wen.
- Cycle latch: a write cycle is latched on the synchronized f_wen 0->1 edge. A read cycle is triggered on the synchronized f_ren 1->0 edge.
- Strobe timing: each f_wen/f_ren low and high phase must last >=2 clk. CLE, ALE and IO must be stable 2 clk before the rising f_wen.
- Write-cycle class: CLE=1,ALE=0 is a command; ALE=1,CLE=0 is an address; CLE=0,ALE=0 is data; CLE=1,ALE=1 is ignored.
- Commands:
  - 00h: column base 0, enter ADDR.
  - 01h: column base 256, enter ADDR.
  - 80h: column base 0, enter ADDR for program.
  - 10h: program confirm.
  - 70h: enter STATUS.
  - FFh: reset.
  - Any other code is ignored and the state is unchanged.
- ADDR: expects 3 address cycles.
  - Byte0 = column[7:0], added to the column base.
  - Byte1 = page[7:0].
  - Byte2 = page[PAGE_BITS-1:8], unused bits ignored.
  - Read path: after the 3rd byte, f_rb=0 on the next clk and go to LOAD.
  - Program path: after the 3rd byte go to DIN.
  - A command cycle before the 3rd byte aborts and is decoded as a new command.
- LOAD: issue 512 consecutive mem_re with mem_addr={page,0..511}; store mem_rdata at column index one cycle later. Then wait TR_CYCLES, set f_rb=1, go to DOUT.
- DOUT: on each read trigger, the next clk sets f_io_out=buf[column] and f_io_oe=1, then column increments. Column 511 wraps to 0 within the same page. f_io_oe returns to 0 one clk after the synchronized f_ren goes high.
- DIN: each data cycle writes buf[column]=data, then column increments with the same wrap. 10h in DIN: f_rb=0, go to PROG. Bytes never written keep their previous buf value.
- PROG: 512 consecutive mem_we with mem_addr={page,0..511}, mem_wdata=buf[i]. Then wait TPROG_CYCLES, set f_rb=1, go to IDLE.
- STATUS: a read trigger drives f_io_out = {1'b1, f_rb, 6'b000000}; valid in any state, including busy. STATUS persists until the next command. 00h/01h are needed to resume data reads.
- While busy (f_rb=0): only 70h and FFh are accepted. All other write cycles are ignored, and read triggers return nothing (f_io_oe stays 0) unless in STATUS.
- FFh in any state: abort LOAD/PROG immediately with mem_re/mem_we=0 next clk, f_rb=0 for TRST_CYCLES, then IDLE with f_rb=1. An aborted PROG leaves a partially written page; this is allowed.
- Simultaneous read and write triggers within one clk (protocol violation): the write takes priority.

Test Plan:
- Reset: rst_n low mid-PROG -> f_rb=1, mem_we=0, f_io_oe=0 immediately; after release, 70h then REN returns C0h.
- Read page: backing memory byte (page 5, col i)=i[7:0]; 00h, addr 00h/05h/00h -> f_rb low for 512+TR_CYCLES(+pipeline) clk, then 512 REN pulses return 00h..FFh,00h..FFh; the 513th returns 00h (wrap).
- Half-page read: 01h, addr 10h/05h/00h -> first REN returns byte at column 272 (10h).
- Program: 80h, addr 00h/07h/00h, 512 data bytes A5h^col[7:0], 10h -> 512 mem_we at addresses 0E00h..0FFFh with matching data, f_rb high after TPROG_CYCLES; read-back of page 7 matches.
- Busy status: 70h during LOAD -> REN returns 80h; after ready returns C0h; a 00h issued while busy is ignored.
- Abort: FFh during PROG at byte 100 -> writes stop, f_rb low exactly TRST_CYCLES, then 70h returns C0h.

Source files
------------

// File: rtl/nand_flash_target.sv
// rtl/nand_flash_target.sv - small-page NAND flash target emulator with page register and busy timing
module nand_flash_target #(
    parameter int PAGE_BITS    = 9,
    parameter int TR_CYCLES    = 50,
    parameter int TPROG_CYCLES = 200,
    parameter int TRST_CYCLES  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             f_io_in,
    output logic [7:0]             f_io_out,
    output logic                   f_io_oe,
    input  logic                   f_cle,
    input  logic                   f_ale,
    input  logic                   f_ren,
    input  logic                   f_wen,
    output logic                   f_rb,
    output logic [PAGE_BITS+8:0]   mem_addr,
    output logic                   mem_re,
    input  logic [7:0]             mem_rdata,
    output logic                   mem_we,
    output logic [7:0]             mem_wdata
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_DOUT, S_DIN, S_PROG, S_RST} state_t;

    state_t                 state_q, state_d;
    logic [11:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic                   wen_p_q, wen_p_d, ren_p_q, ren_p_d;
    logic                   status_q, status_d, prog_q, prog_d, rb_q, rb_d, oe_q, oe_d;
    logic                   mem_re_q, mem_re_d, mem_we_q, mem_we_d, rvalid_q, rvalid_d;
    logic [7:0]             io_out_q, io_out_d, mem_wdata_q, mem_wdata_d;
    logic [PAGE_BITS+8:0]   mem_addr_q, mem_addr_d;
    logic [8:0]             col_q, col_d, ridx_q, ridx_d;
    logic [PAGE_BITS-1:0]   page_q, page_d;
    logic [9:0]             idx_q, idx_d;
    logic [1:0]             acnt_q, acnt_d;
    logic [15:0]            wait_q, wait_d;

    logic [7:0]             page_buf [512];
    logic                   buf_we;
    logic [8:0]             buf_waddr;
    logic [7:0]             buf_wdata;
    logic                   cle_s, ale_s, wen_s, ren_s, wr_trig, rd_trig;
    logic [7:0]             io_s;

    assign {cle_s, ale_s, wen_s, ren_s, io_s} = sync2_q;

    always_comb begin
        sync1_d     = {f_cle, f_ale, f_wen, f_ren, f_io_in};
        sync2_d     = sync1_q;
        wen_p_d     = wen_s;
        ren_p_d     = ren_s;
        state_d     = state_q;
        status_d    = status_q;
        prog_d      = prog_q;
        rb_d        = rb_q;
        oe_d        = oe_q;
        io_out_d    = io_out_q;
        col_d       = col_q;
        page_d      = page_q;
        idx_d       = idx_q;
        acnt_d      = acnt_q;
        wait_d      = wait_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rvalid_d    = mem_re_q;
        ridx_d      = mem_addr_q[8:0];
        buf_we      = rvalid_q;
        buf_waddr   = ridx_q;
        buf_wdata   = mem_rdata;
        wr_trig     = wen_s && !wen_p_q;
        rd_trig     = !ren_s && ren_p_q && !wr_trig;

        if (ren_s) oe_d = 1'b0;

        // Background page transfer and busy timers; commands below may override.
        case (state_q)
            S_LOAD, S_PROG: begin
                if (!idx_q[9]) begin
                    mem_re_d    = (state_q == S_LOAD);
                    mem_we_d    = (state_q == S_PROG);
                    mem_addr_d  = {page_q, idx_q[8:0]};
                    mem_wdata_d = page_buf[idx_q[8:0]];
                    idx_d       = idx_q + 10'd1;
                    if (idx_q == 10'd511)
                        wait_d = (state_q == S_LOAD) ? 16'(TR_CYCLES + 1) : 16'(TPROG_CYCLES);
                end else if (wait_q == 16'd0) begin
                    rb_d    = 1'b1;
                    state_d = (state_q == S_LOAD) ? S_DOUT : S_IDLE;
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            S_RST: begin
                if (wait_q == 16'd0) begin
                    rb_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            default: ;
        endcase

        if (wr_trig) begin
            if (cle_s && !ale_s) begin
                if (io_s == 8'hFF) begin
                    state_d  = S_RST;
                    rb_d     = 1'b0;
                    wait_d   = 16'(TRST_CYCLES - 1);
                    status_d = 1'b0;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                end else if (io_s == 8'h70) begin
                    status_d = 1'b1;
                    if (state_q == S_ADDR) state_d = S_IDLE;
                end else if (rb_q) begin
                    case (io_s)
                        8'h00, 8'h01, 8'h80: begin
                            col_d    = (io_s == 8'h01) ? 9'd256 : 9'd0;
                            prog_d   = (io_s == 8'h80);
                            acnt_d   = 2'd0;
                            status_d = 1'b0;
                            state_d  = S_ADDR;
                        end
                        8'h10: begin
                            if (state_q == S_DIN) begin
                                status_d = 1'b0;
                                rb_d     = 1'b0;
                                idx_d    = 10'd0;
                                state_d  = S_PROG;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (ale_s && !cle_s && rb_q && state_q == S_ADDR) begin
                acnt_d = acnt_q + 2'd1;
                case (acnt_q)
                    2'd0:    col_d  = col_q + {1'b0, io_s};
                    2'd1:    page_d = PAGE_BITS'(io_s);
                    default: begin
                        page_d = PAGE_BITS'({io_s, page_q[7:0]});
                        if (prog_q) begin
                            state_d = S_DIN;
                        end else begin
                            rb_d    = 1'b0;
                            idx_d   = 10'd0;
                            state_d = S_LOAD;
                        end
                    end
                endcase
            end else if (!ale_s && !cle_s && rb_q && state_q == S_DIN) begin
                buf_we    = 1'b1;
                buf_waddr = col_q;
                buf_wdata = io_s;
                col_d     = col_q + 9'd1;
            end
        end else if (rd_trig) begin
            if (status_q) begin
                io_out_d = {1'b1, rb_q, 6'b000000};
                oe_d     = 1'b1;
            end else if (state_q == S_DOUT && rb_q) begin
                io_out_d = page_buf[col_q];
                oe_d     = 1'b1;
                col_d    = col_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 12'h300;
            sync2_q     <= 12'h300;
            wen_p_q     <= 1'b1;
            ren_p_q     <= 1'b1;
            status_q    <= 1'b0;
            prog_q      <= 1'b0;
            rb_q        <= 1'b1;
            oe_q        <= 1'b0;
            io_out_q    <= 8'h00;
            col_q       <= 9'd0;
            page_q      <= '0;
            idx_q       <= 10'd0;
            acnt_q      <= 2'd0;
            wait_q      <= 16'd0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            rvalid_q    <= 1'b0;
            ridx_q      <= 9'd0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            wen_p_q     <= wen_p_d;
            ren_p_q     <= ren_p_d;
            status_q    <= status_d;
            prog_q      <= prog_d;
            rb_q        <= rb_d;
            oe_q        <= oe_d;
            io_out_q    <= io_out_d;
            col_q       <= col_d;
            page_q      <= page_d;
            idx_q       <= idx_d;
            acnt_q      <= acnt_d;
            wait_q      <= wait_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rvalid_q    <= rvalid_d;
            ridx_q      <= ridx_d;
        end
    end

    // Page register keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (buf_we) page_buf[buf_waddr] <= buf_wdata;
    end

    assign f_io_out  = io_out_q;
    assign f_io_oe   = oe_q;
    assign f_rb      = rb_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_nand_flash_target.sv
// tb/tb_nand_flash_target.sv - directed self-checking bench for nand_flash_target
module tb_nand_flash_target;

    localparam int PB    = 9;
    localparam int TR    = 50;
    localparam int TPROG = 200;
    localparam int TRST  = 8;
    localparam int MEMSZ = 1 << (PB + 9);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    f_io_in = 8'h00;
    logic          f_cle = 1'b0, f_ale = 1'b0, f_ren = 1'b1, f_wen = 1'b1;
    logic [7:0]    f_io_out;
    logic          f_io_oe, f_rb, mem_re, mem_we;
    logic [PB+8:0] mem_addr;
    logic [7:0]    mem_rdata, mem_wdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]    mem [MEMSZ];
    logic [PB+8:0] wlog_addr [$];
    logic [7:0]    wlog_data [$];

    nand_flash_target #(.PAGE_BITS(PB), .TR_CYCLES(TR), .TPROG_CYCLES(TPROG), .TRST_CYCLES(TRST)) dut (
        .clk(clk), .rst_n(rst_n), .f_io_in(f_io_in), .f_io_out(f_io_out), .f_io_oe(f_io_oe),
        .f_cle(f_cle), .f_ale(f_ale), .f_ren(f_ren), .f_wen(f_wen), .f_rb(f_rb),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_cycle(input logic cle, input logic ale, input logic [7:0] d);
        f_cle = cle; f_ale = ale; f_io_in = d;
        tick(2);
        f_wen = 1'b0;
        tick(3);
        f_wen = 1'b1;
        tick(4);
        f_cle = 1'b0; f_ale = 1'b0;
    endtask

    task automatic rd_cycle(output logic [7:0] d, output logic oe);
        f_ren = 1'b0;
        tick(4);
        d  = f_io_out;
        oe = f_io_oe;
        f_ren = 1'b1;
        tick(4);
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (f_rb !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset;
        logic [7:0] d; logic oe;
        total++; if (f_rb !== 1'b1) begin bad++; $display("FAIL reset_rb: got %b want 1", f_rb); end
        total++; if (f_io_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", f_io_oe); end
        total++; if (f_io_out !== 8'h00) begin bad++; $display("FAIL reset_io_out: got %h want 00", f_io_out); end
        total++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_strobes: re=%b we=%b want 0 0", mem_re, mem_we); end
        total++; if (mem_addr !== '0 || mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
        rst_n = 1'b1;
        tick(3);
        wr_cycle(1'b1, 1'b0, 8'h70);
        rd_cycle(d, oe);
        total++; if (d !== 8'hC0 || oe !== 1'b1) begin bad++; $display("FAIL reset_status: got %h oe=%b want C0 oe=1", d, oe); end
    endtask

    task automatic test_read_page;
        logic [7:0] d; logic oe; int n, errs, first;
        wr_cycle(1'b1, 1'b0, 8'h00);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wr_cycle(1'b0, 1'b1, 8'h05);
        wr_cycle(1'b0, 1'b1, 8'h00);
        total++; if (f_rb !== 1'b0) begin bad++; $display("FAIL read_busy_start: rb=%b want 0", f_rb); end
        wait_ready(2000, n);
        total++;
        if (f_rb !== 1'b1 || n < 512 + TR - 4 || n > 512 + TR + 10) begin
            bad++; $display("FAIL read_busy_len: rb=%b cycles=%0d want about %0d", f_rb, n, 512 + TR + 1);
        end
        errs = 0; first = -1;
        for (int i = 0; i < 512; i++) begin
            rd_cycle(d, oe);
            if (d !== i[7:0] || oe !== 1'b1) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
        total++; if (errs != 0) begin bad++; $display("FAIL read_page_data: %0d bad bytes first col %0d want byte=col", errs, first); end
        rd_cycle(d, oe);
        total++; if (d !== 8'h00 || oe !== 1'b1) begin bad++; $display("FAIL read_wrap: got %h want 00", d); end
    endtask

    task automatic test_half_page;
        logic [7:0] d; logic oe; int n;
        wr_cycle(1'b1, 1'b0, 8'h01);
        wr_cycle(1'b0, 1'b1, 8'h10);
        wr_cycle(1'b0, 1'b1, 8'h05);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wait_ready(2000, n);
        total++; if (f_rb !== 1'b1) begin bad++; $display("FAIL half_ready: rb=%b after %0d cycles want 1", f_rb, n); end
        rd_cycle(d, oe);
        total++; if (d !== 8'h10 || oe !== 1'b1) begin bad++; $display("FAIL half_first: got %h want 10", d); end
        rd_cycle(d, oe);
        total++; if (d !== 8'h11) begin bad++; $display("FAIL half_second: got %h want 11", d); end
        total++; if (f_io_oe !== 1'b0) begin bad++; $display("FAIL oe_release: got %b want 0", f_io_oe); end
    endtask

    task automatic test_program;
        logic [7:0] d; logic oe; int n, errs, first;
        logic [PB+8:0] ea;
        wr_cycle(1'b1, 1'b0, 8'h80);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wr_cycle(1'b0, 1'b1, 8'h07);
        wr_cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 512; i++) wr_cycle(1'b0, 1'b0, 8'hA5 ^ i[7:0]);
        wlog_addr.delete(); wlog_data.delete();
        wr_cycle(1'b1, 1'b0, 8'h10);
        total++; if (f_rb !== 1'b0) begin bad++; $display("FAIL prog_busy_start: rb=%b want 0", f_rb); end
        wait_ready(3000, n);
        total++;
        if (f_rb !== 1'b1 || n < 512 + TPROG - 4 || n > 512 + TPROG + 10) begin
            bad++; $display("FAIL prog_busy_len: rb=%b cycles=%0d want about %0d", f_rb, n, 512 + TPROG);
        end
        total++; if (wlog_addr.size() != 512) begin bad++; $display("FAIL prog_count: got %0d writes want 512", wlog_addr.size()); end
        errs = 0; first = -1;
        for (int i = 0; i < wlog_addr.size() && i < 512; i++) begin
            ea = {9'd7, i[8:0]};
            if (wlog_addr[i] !== ea || wlog_data[i] !== (8'hA5 ^ i[7:0])) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
        total++; if (errs != 0) begin bad++; $display("FAIL prog_writes: %0d bad writes first index %0d want addr 0E00h+i data A5h^i", errs, first); end
        wr_cycle(1'b1, 1'b0, 8'h00);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wr_cycle(1'b0, 1'b1, 8'h07);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wait_ready(2000, n);
        errs = 0; first = -1;
        for (int i = 0; i < 512; i++) begin
            rd_cycle(d, oe);
            if (d !== (8'hA5 ^ i[7:0]) || oe !== 1'b1) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
        total++; if (errs != 0) begin bad++; $display("FAIL prog_readback: %0d bad bytes first col %0d want A5h^col", errs, first); end
    endtask

    task automatic test_busy_status;
        logic [7:0] d; logic oe; int n;
        wr_cycle(1'b1, 1'b0, 8'h00);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wr_cycle(1'b0, 1'b1, 8'h05);
        wr_cycle(1'b0, 1'b1, 8'h00);
        rd_cycle(d, oe);
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL busy_read_oe: got %b want 0", oe); end
        wr_cycle(1'b1, 1'b0, 8'h70);
        rd_cycle(d, oe);
        total++; if (d !== 8'h80 || oe !== 1'b1) begin bad++; $display("FAIL busy_status: got %h oe=%b want 80 oe=1", d, oe); end
        wr_cycle(1'b1, 1'b0, 8'h00);
        wait_ready(2000, n);
        total++; if (f_rb !== 1'b1) begin bad++; $display("FAIL busy_ready: rb=%b after %0d cycles want 1", f_rb, n); end
        rd_cycle(d, oe);
        total++; if (d !== 8'hC0 || oe !== 1'b1) begin bad++; $display("FAIL ready_status: got %h want C0", d); end
    endtask

    task automatic test_abort;
        logic [7:0] d; logic oe; int n, cnt, sz; bit found;
        wr_cycle(1'b1, 1'b0, 8'h80);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wr_cycle(1'b0, 1'b1, 8'h09);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wlog_addr.delete(); wlog_data.delete();
        wr_cycle(1'b1, 1'b0, 8'h10);
        n = 0;
        while (wlog_addr.size() < 90 && n < 600) begin tick(1); n++; end
        f_cle = 1'b1; f_ale = 1'b0; f_io_in = 8'hFF;
        tick(2);
        f_wen = 1'b0;
        tick(3);
        f_wen = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick(1);
            if (mem_we === 1'b0) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL abort_we_stop: mem_we=%b want 0", mem_we); end
        cnt = 0;
        while (f_rb === 1'b0 && cnt < 100) begin cnt++; tick(1); end
        f_cle = 1'b0;
        total++; if (cnt != TRST) begin bad++; $display("FAIL abort_rst_busy: got %0d cycles want %0d", cnt, TRST); end
        sz = wlog_addr.size();
        total++; if (sz < 90 || sz >= 512) begin bad++; $display("FAIL abort_partial: got %0d writes want 90..511", sz); end
        tick(20);
        total++; if (wlog_addr.size() != sz) begin bad++; $display("FAIL abort_no_more_writes: got %0d want %0d", wlog_addr.size(), sz); end
        wr_cycle(1'b1, 1'b0, 8'h70);
        rd_cycle(d, oe);
        total++; if (d !== 8'hC0 || oe !== 1'b1) begin bad++; $display("FAIL abort_status: got %h want C0", d); end
    endtask

    task automatic test_reset_mid_prog;
        logic [7:0] d; logic oe;
        wr_cycle(1'b1, 1'b0, 8'h80);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wr_cycle(1'b0, 1'b1, 8'h0A);
        wr_cycle(1'b0, 1'b1, 8'h00);
        wr_cycle(1'b1, 1'b0, 8'h10);
        tick(20);
        total++; if (mem_we !== 1'b1 || f_rb !== 1'b0) begin bad++; $display("FAIL rst_pre_prog: we=%b rb=%b want 1 0", mem_we, f_rb); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (f_rb !== 1'b1 || mem_we !== 1'b0 || f_io_oe !== 1'b0 || mem_addr !== '0) begin
            bad++; $display("FAIL rst_async: rb=%b we=%b oe=%b addr=%h want 1 0 0 0", f_rb, mem_we, f_io_oe, mem_addr);
        end
        tick(3);
        rst_n = 1'b1;
        tick(3);
        wr_cycle(1'b1, 1'b0, 8'h70);
        rd_cycle(d, oe);
        total++; if (d !== 8'hC0 || oe !== 1'b1) begin bad++; $display("FAIL rst_status: got %h want C0", d); end
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h00;
        for (int i = 0; i < 512; i++) begin
            mem[(5 << 9) + i] = i[7:0];
            mem[(7 << 9) + i] = 8'h33;
        end
        tick(3);
        test_reset;
        test_read_page;
        test_half_page;
        test_program;
        test_busy_status;
        test_abort;
        test_reset_mid_prog;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
